// File: rtl/aes_bridge_pkg.sv
// Shared constants and encodings for the AES word bridge.
package aes_bridge_pkg;

  localparam int WORD_W  = 16;
  localparam int BLOCK_W = 128;
  localparam int WORDS   = BLOCK_W / WORD_W;

  // Bridge sequencing: gather words, request the core, wait for it, hand words back.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Direction of the AES operation as presented to the core.
  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_t;

endpackage

// File: rtl/aes_word_bridge_if.sv
// Signal bundle between the bridge, the pipeline execute stage and the AES core.
interface aes_word_bridge_if;
  import aes_bridge_pkg::*;

  // Pipeline side
  logic               wr_en_i;
  logic [WORD_W-1:0]  wr_data_i;
  logic               mode_i;
  logic               rd_en_i;
  logic [WORD_W-1:0]  rd_data_o;
  logic               rd_valid_o;
  logic               stall_o;

  // AES core side
  logic               aes_valid_o;
  logic               aes_ready_i;
  logic [BLOCK_W-1:0] aes_data_o;
  logic               aes_decrypt_o;
  logic               aes_done_i;
  logic [BLOCK_W-1:0] aes_data_i;

  // The bridge itself
  modport slave (
    input  wr_en_i, wr_data_i, mode_i, rd_en_i,
    input  aes_ready_i, aes_done_i, aes_data_i,
    output rd_data_o, rd_valid_o, stall_o,
    output aes_valid_o, aes_data_o, aes_decrypt_o
  );

  // Whoever drives the bridge: pipeline plus core
  modport master (
    output wr_en_i, wr_data_i, mode_i, rd_en_i,
    output aes_ready_i, aes_done_i, aes_data_i,
    input  rd_data_o, rd_valid_o, stall_o,
    input  aes_valid_o, aes_data_o, aes_decrypt_o
  );

endinterface

// File: rtl/aes_word_bridge.sv
// Narrow-to-wide adapter: packs eight pipeline words into one AES block,
// hands it to the core, then returns the core result one word at a time.
module aes_word_bridge (
  input  logic            clk_i,
  input  logic            reset_n,
  aes_word_bridge_if.slave bus
);
  import aes_bridge_pkg::*;

  localparam int               CNT_W     = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS - 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  wr_cnt_reg;
  logic [CNT_W-1:0]  rd_cnt_reg;
  mode_t             mode_reg;
  logic              aes_valid_reg;
  logic              rd_valid_reg;
  logic [WORD_W-1:0] in_words_reg  [WORDS];
  logic [WORD_W-1:0] res_words_reg [WORDS];

  // A request is held off whenever it does not belong to the current phase.
  assign bus.stall_o = (bus.wr_en_i && (state_reg != FILL)) ||
                       (bus.rd_en_i && (state_reg != DRAIN));

  assign bus.aes_valid_o   = aes_valid_reg;
  assign bus.rd_valid_o    = rd_valid_reg;
  assign bus.aes_decrypt_o = (mode_reg == DEC);
  assign bus.rd_data_o     = res_words_reg[rd_cnt_reg];

  // Slot 0 lands in the most significant word of the block.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_pack
      assign bus.aes_data_o[BLOCK_W-1-gi*WORD_W -: WORD_W] = in_words_reg[gi];
    end
  endgenerate

  // Sequencer: counters, block/result capture and the registered handshake flags.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_reg     <= FILL;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      mode_reg      <= ENC;
      aes_valid_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        in_words_reg[i]  <= '0;
        res_words_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        FILL: begin
          if (bus.wr_en_i) begin
            in_words_reg[wr_cnt_reg] <= bus.wr_data_i;
            if (wr_cnt_reg == LAST_SLOT) begin
              wr_cnt_reg    <= '0;
              mode_reg      <= mode_t'(bus.mode_i);
              aes_valid_reg <= 1'b1;
              state_reg     <= REQ;
            end else begin
              wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
          end
        end
        REQ: begin
          // Block and mode stay frozen here because writes stall outside FILL.
          if (bus.aes_ready_i) begin
            aes_valid_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.aes_done_i) begin
            for (int i = 0; i < WORDS; i++) begin
              res_words_reg[i] <= bus.aes_data_i[BLOCK_W-1-i*WORD_W -: WORD_W];
            end
            rd_valid_reg <= 1'b1;
            state_reg    <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.rd_en_i) begin
            if (rd_cnt_reg == LAST_SLOT) begin
              rd_cnt_reg   <= '0;
              rd_valid_reg <= 1'b0;
              state_reg    <= FILL;
            end else begin
              rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

endmodule

// File: doc/aes_word_bridge.md
# aes_word_bridge

- Adapter between the 16-bit CPU pipeline's AES instructions and the 128-bit AES core.
- Collects eight 16-bit words from the execute stage into one 128-bit block and hands the block to the core over a valid/ready handshake.
- Captures the core's 128-bit result and returns it to the pipeline as eight 16-bit reads.
- Drives a combinational stall back to the pipeline while a request cannot be serviced.

## Interface
Parameters:
- WORD_W, 16, pipeline word width.
- BLOCK_W, 128, AES block width; WORDS = BLOCK_W/WORD_W = 8.

Ports:
- clk_i  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- wr_en_i  in  1  pipeline pushes one plaintext/ciphertext word.
- wr_data_i  in  WORD_W  word being pushed.
- mode_i  in  1  0 = encrypt, 1 = decrypt; sampled with the last (8th) write.
- rd_en_i  in  1  pipeline pops one result word.
- rd_data_o  out  WORD_W  current result word.
- rd_valid_o  out  1  result word available (state DRAIN).
- stall_o  out  1  combinational; pipeline must hold the current AES instruction.
- aes_valid_o  out  1  block request to the core.
- aes_ready_i  in  1  core accepts the request.
- aes_data_o  out  BLOCK_W  packed input block.
- aes_decrypt_o  out  1  latched mode.
- aes_done_i  in  1  one-cycle pulse, result valid.
- aes_data_i  in  BLOCK_W  core result.

## Operation
States are FILL, REQ, WAIT and DRAIN.

FILL:
- wr_en_i writes wr_data_i to slot wr_cnt (0..7), then increments wr_cnt.
- Packing is MSB-first: slot 0 maps to bits 127:112, slot 7 to bits 15:0.
- On the write with wr_cnt == 7, latch mode_i, clear wr_cnt, and go to REQ.

REQ:
- aes_valid_o = 1.
- aes_data_o and aes_decrypt_o are held stable.
- On aes_ready_i, go to WAIT.

WAIT:
- On aes_done_i, latch aes_data_i into the result register and go to DRAIN.
- aes_done_i in any other state is ignored.

DRAIN:
- rd_valid_o = 1; rd_data_o = result slot rd_cnt, using the same MSB-first order.
- rd_en_i increments rd_cnt.
- On the pop with rd_cnt == 7, clear rd_cnt and go to FILL.

Stall:
- stall_o = (wr_en_i & state != FILL) | (rd_en_i & state != DRAIN).
- A stalled request has no side effect and is retried by the pipeline.

Other rules:
- wr_en_i and rd_en_i asserted together: only the request legal in the current state is serviced; the other stalls.
- rd_data_o outside DRAIN holds the last result slot addressed; it is not defined as a value.

Reset (reset_n low at a rising edge, including mid-operation):
- State returns to FILL; wr_cnt, rd_cnt and mode are cleared; the input block and result registers are cleared to 0.
- A late aes_done_i arriving after reset is ignored.

## Timing
Reset values:
- aes_valid_o = 0, rd_valid_o = 0, rd_data_o = 0, aes_data_o = 0, aes_decrypt_o = 0.
- stall_o = 0 with both enables low.

Latencies:
- 8th write accepted at edge t: aes_valid_o is high from t+1.
- aes_valid_o & aes_ready_i at edge u: aes_valid_o is low from u+1.
- aes_done_i at edge v: rd_valid_o is high and rd_data_o = result[127:112] from v+1.
- Each accepted rd_en_i presents the next word in the following cycle.
- Last pop at edge w: FILL from w+1; wr_en_i is accepted from w+1.

Handshake:
- aes_valid_o never drops before ready is seen.
- The core must not pulse done in the same cycle as the ready handshake.

Throughput:
- Zero bubbles inside FILL and inside DRAIN: one word per cycle with the enable held.

## Structure
- Package aes_bridge_pkg: WORD_W, BLOCK_W and WORDS constants, the state enum (FILL, REQ, WAIT, DRAIN), and the mode encoding (ENC = 0, DEC = 1).
- No sub-module: the FSM, two 3-bit counters, and the 128-bit input and result registers live in aes_word_bridge.
- The bench provides a behavioural AES core model with programmable ready and done delays.

## Test plan
- Encrypt vector:
  - Stimulus: write 3243, F6A8, 885A, 308D, 3131, 98A2, E037, 0734 with mode 0.
  - Required: aes_data_o = 3243F6A8885A308D313198A2E0370734 and aes_decrypt_o = 0.
  - Model returns 3925841D02DC09FBDC118597196A0B32; eight pops give 3925, 841D, 02DC, 09FB, DC11, 8597, 196A, 0B32, then FILL.
- Decrypt round trip:
  - Stimulus: write the ciphertext words above with mode 1.
  - Required: aes_decrypt_o = 1; pops return the plaintext words 3243 … 0734.
- Backpressure:
  - Stimulus: hold aes_ready_i low for 5 cycles, then raise it.
  - Required: aes_valid_o and aes_data_o stay stable the whole time; exactly one handshake; state WAIT after.
- Stalls:
  - Stimulus: wr_en_i in REQ/WAIT/DRAIN, rd_en_i in FILL/REQ/WAIT, and both enables together in FILL and in DRAIN.
  - Required: stall_o = 1 for the illegal request in each case; counters and registers unchanged by it; the legal request is serviced.
- Reset mid-operation:
  - Stimulus: reset_n low after 4 writes; reset_n low in WAIT followed by an aes_done_i.
  - Required: next cycle all outputs are at reset values and wr_cnt = 0; the late done pulse is ignored; a fresh 8-word block works.
- Spurious done and back-to-back:
  - Stimulus: aes_done_i pulsed in FILL and in REQ; then two blocks back-to-back with minimum core delays.
  - Required: spurious done pulses are ignored; second-block writes are accepted the cycle after the last pop; both results are correct.
